s2mm_packet_arbiter: RTL and testbench

Multi-channel, packet-atomic arbiter that drains per-accelerator FIFOs into the slave S2MM AXI-Stream port of the MCDMA. It sits between the accelerator output FIFOs and the MCDMA. Channels are granted round-robin, and a grant is held for a whole packet so beats from different channels never interleave. It provides a registered AXIS output with full tready back-pressure, tdest set to the channel index, and a per-packet beat limit that forces tlast on runaway packets.

---
 rtl/s2mm_packet_arbiter.sv | 211 +++++++++++++++++++++
 tb/tb_s2mm_packet_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/s2mm_packet_arbiter.sv
// -----------------------------------------------------------------------------
// s2mm_packet_arbiter
//
// Packet-atomic round-robin arbiter that drains per-accelerator FWFT FIFOs
// into the S2MM AXI-Stream slave port of the MCDMA. A grant is held for a
// whole packet, so beats from different channels never interleave. tdest
// carries the channel index. A per-packet beat limit forces tlast (and flags
// it on tuser) when a producer never terminates its packet.
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   SINK_AXIS_*             registered AXIS master toward the MCDMA
//                           (tkeep constant all ones, tuser = forced tlast)
//   fifo_data_in            FWFT head words, channel i at [i*FW +: FW]
//   fifo_not_empty_in       head word valid, per channel
//   fifo_last_in            head word is the last word of its packet
//   fifo_r_stb_out          pop strobe, one-hot or zero (combinational)
//   channel_mask_in         1 = channel may win a new grant
//   cur_chan_out            currently / last granted channel
//   pkt_trunc_out           one-cycle pulse with a beat whose tlast was forced
//   dbg_state_out           FSM state: 0 IDLE, 1 XFER
//
// Handshake: a beat transfers on a rising edge where tvalid=1 and tready=1.
// Once tvalid is raised, tdata/tdest/tlast/tuser/tvalid hold until that edge.
// A FIFO word is consumed on a rising edge where its fifo_r_stb_out bit is 1.
// -----------------------------------------------------------------------------
module s2mm_packet_arbiter #(
  parameter int AXIS_DATA_WIDTH = 32,
  parameter int FIFO_DATA_WIDTH = 32,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_DEST_WIDTH = 4,
  parameter int NUM_CHANNELS    = 4,
  parameter int MAX_PKT_BEATS   = 1024
) (
  input  logic                                    clk_in,
  input  logic                                    rst_n_in,
  input  logic                                    SINK_AXIS_tready_in,
  output logic [AXIS_DATA_WIDTH-1:0]              SINK_AXIS_tdata_out,
  output logic [AXIS_DEST_WIDTH-1:0]              SINK_AXIS_tdest_out,
  output logic [AXIS_KEEP_WIDTH-1:0]              SINK_AXIS_tkeep_out,
  output logic                                    SINK_AXIS_tlast_out,
  output logic                                    SINK_AXIS_tuser_out,
  output logic                                    SINK_AXIS_tvalid_out,
  input  logic [FIFO_DATA_WIDTH*NUM_CHANNELS-1:0] fifo_data_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_not_empty_in,
  input  logic [NUM_CHANNELS-1:0]                 fifo_last_in,
  output logic [NUM_CHANNELS-1:0]                 fifo_r_stb_out,
  input  logic [NUM_CHANNELS-1:0]                 channel_mask_in,
  output logic [AXIS_DEST_WIDTH-1:0]              cur_chan_out,
  output logic                                    pkt_trunc_out,
  output logic [1:0]                              dbg_state_out
);

  localparam int GW  = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int BCW = $clog2(MAX_PKT_BEATS + 1);

  localparam logic [GW-1:0]  LAST_CH       = GW'(NUM_CHANNELS - 1);
  localparam logic [BCW-1:0] BEAT_LIMIT_M1 = BCW'(MAX_PKT_BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1
  } state_t;

  state_t               state_q;
  state_t               state_d;
  logic [GW-1:0]        grant_q;
  logic [GW-1:0]        last_grant_q;
  logic [BCW-1:0]       beat_cnt_q;

  logic [AXIS_DATA_WIDTH-1:0] tdata_q;
  logic [AXIS_DEST_WIDTH-1:0] tdest_q;
  logic                       tlast_q;
  logic                       tuser_q;
  logic                       tvalid_q;
  logic                       trunc_q;

  logic [NUM_CHANNELS-1:0]    req;
  logic                       arb_found;
  logic [GW-1:0]              arb_idx;
  logic [GW-1:0]              cand;
  logic [FIFO_DATA_WIDTH-1:0] fifo_word [NUM_CHANNELS];

  logic head_valid;
  logic head_last;
  logic pop;
  logic limit_hit;
  logic forced_end;
  logic pkt_end;
  logic do_grant;

  // Unpack the flat FIFO data bus into one word per channel.
  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_word
    assign fifo_word[g] = fifo_data_in[g*FIFO_DATA_WIDTH +: FIFO_DATA_WIDTH];
  end

  assign req = fifo_not_empty_in & channel_mask_in;

  // Round-robin search: first requester at or after last_grant+1, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int i = 1; i <= NUM_CHANNELS; i++) begin
      cand = GW'((int'(last_grant_q) + i) % NUM_CHANNELS);
      if (!arb_found && req[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Pop whenever the granted FIFO has a word and the output register is free
  // or draining this cycle.
  assign head_valid = fifo_not_empty_in[grant_q];
  assign head_last  = fifo_last_in[grant_q];
  assign pop        = (state_q == ST_XFER) && head_valid &&
                      (!tvalid_q || SINK_AXIS_tready_in);
  assign limit_hit  = (beat_cnt_q == BEAT_LIMIT_M1);
  assign forced_end = limit_hit && !head_last;
  assign pkt_end    = pop && (head_last || limit_hit);

  always_comb begin
    fifo_r_stb_out          = '0;
    fifo_r_stb_out[grant_q] = pop;
  end

  // FSM: state register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state. IDLE is the single arbitration cycle between packets.
  always_comb begin
    state_d  = state_q;
    do_grant = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (arb_found) begin
          state_d  = ST_XFER;
          do_grant = 1'b1;
        end
      end
      ST_XFER: begin
        // An empty FIFO mid-packet keeps the grant; no timeout by design.
        if (pkt_end) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Grant bookkeeping and beat counter. The counter never passes
  // MAX_PKT_BEATS because the packet ends on the beat that reaches it.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      grant_q      <= '0;
      last_grant_q <= LAST_CH;
      beat_cnt_q   <= '0;
    end else begin
      if (do_grant) begin
        grant_q      <= arb_idx;
        last_grant_q <= arb_idx;
        beat_cnt_q   <= '0;
      end else if (pop) begin
        beat_cnt_q <= beat_cnt_q + BCW'(1);
      end
    end
  end

  // Registered AXIS output stage. Loads only on pop, which is only allowed
  // when the register is empty or being accepted, so a stalled beat holds.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tdata_q  <= '0;
      tdest_q  <= '0;
      tlast_q  <= 1'b0;
      tuser_q  <= 1'b0;
      tvalid_q <= 1'b0;
      trunc_q  <= 1'b0;
    end else begin
      trunc_q <= 1'b0;
      if (pop) begin
        tdata_q  <= AXIS_DATA_WIDTH'(fifo_word[grant_q]);
        tdest_q  <= AXIS_DEST_WIDTH'(grant_q);
        tlast_q  <= head_last || limit_hit;
        tuser_q  <= forced_end;
        tvalid_q <= 1'b1;
        trunc_q  <= forced_end;
      end else if (SINK_AXIS_tready_in) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign SINK_AXIS_tdata_out  = tdata_q;
  assign SINK_AXIS_tdest_out  = tdest_q;
  assign SINK_AXIS_tkeep_out  = '1;
  assign SINK_AXIS_tlast_out  = tlast_q;
  assign SINK_AXIS_tuser_out  = tuser_q;
  assign SINK_AXIS_tvalid_out = tvalid_q;
  assign pkt_trunc_out        = trunc_q;
  assign cur_chan_out         = AXIS_DEST_WIDTH'(grant_q);
  assign dbg_state_out        = state_q;

endmodule

// File: tb/tb_s2mm_packet_arbiter.sv
// -----------------------------------------------------------------------------
// tb_s2mm_packet_arbiter
//
// Directed bench for s2mm_packet_arbiter (4 channels, MAX_PKT_BEATS=4).
// Per-channel FWFT FIFOs are modelled as small arrays; each cycle the bench
// samples DUT outputs 2 time units after the rising edge, logs accepted beats
// with their cycle number, and pops the FIFO model on the strobe seen before
// the edge. Expected beats and cycles are written by hand into exp_q.
// -----------------------------------------------------------------------------
module tb_s2mm_packet_arbiter;

  localparam int DW   = 32;
  localparam int FW   = 32;
  localparam int KW   = 4;
  localparam int DSTW = 4;
  localparam int NCH  = 4;
  localparam int MAXB = 4;
  localparam int LOGN = 1024;

  // clock / reset
  logic clk_in   = 1'b0;
  logic rst_n_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic                  SINK_AXIS_tready_in;
  logic [DW-1:0]         SINK_AXIS_tdata_out;
  logic [DSTW-1:0]       SINK_AXIS_tdest_out;
  logic [KW-1:0]         SINK_AXIS_tkeep_out;
  logic                  SINK_AXIS_tlast_out;
  logic                  SINK_AXIS_tuser_out;
  logic                  SINK_AXIS_tvalid_out;
  logic [FW*NCH-1:0]     fifo_data_in;
  logic [NCH-1:0]        fifo_not_empty_in;
  logic [NCH-1:0]        fifo_last_in;
  logic [NCH-1:0]        fifo_r_stb_out;
  logic [NCH-1:0]        channel_mask_in;
  logic [DSTW-1:0]       cur_chan_out;
  logic                  pkt_trunc_out;
  logic [1:0]            dbg_state_out;

  s2mm_packet_arbiter #(
    .AXIS_DATA_WIDTH (DW),
    .FIFO_DATA_WIDTH (FW),
    .AXIS_KEEP_WIDTH (KW),
    .AXIS_DEST_WIDTH (DSTW),
    .NUM_CHANNELS    (NCH),
    .MAX_PKT_BEATS   (MAXB)
  ) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .SINK_AXIS_tready_in  (SINK_AXIS_tready_in),
    .SINK_AXIS_tdata_out  (SINK_AXIS_tdata_out),
    .SINK_AXIS_tdest_out  (SINK_AXIS_tdest_out),
    .SINK_AXIS_tkeep_out  (SINK_AXIS_tkeep_out),
    .SINK_AXIS_tlast_out  (SINK_AXIS_tlast_out),
    .SINK_AXIS_tuser_out  (SINK_AXIS_tuser_out),
    .SINK_AXIS_tvalid_out (SINK_AXIS_tvalid_out),
    .fifo_data_in         (fifo_data_in),
    .fifo_not_empty_in    (fifo_not_empty_in),
    .fifo_last_in         (fifo_last_in),
    .fifo_r_stb_out       (fifo_r_stb_out),
    .channel_mask_in      (channel_mask_in),
    .cur_chan_out         (cur_chan_out),
    .pkt_trunc_out        (pkt_trunc_out),
    .dbg_state_out        (dbg_state_out)
  );

  // FIFO model: {last, data}
  logic [32:0] fmem [NCH][32];
  int          fhead [NCH];
  int          ftail [NCH];

  // per-cycle logs
  int          cyc;
  logic [63:0] out_log   [LOGN];
  logic        vld_log   [LOGN];
  logic [3:0]  stb_log   [LOGN];
  logic        trunc_log [LOGN];
  logic [1:0]  dbg_log   [LOGN];
  logic [3:0]  chan_log  [LOGN];

  // scoreboard
  logic [63:0] exp_q [$];
  int          exp_cyc [$];
  logic [63:0] got_q [$];
  int          got_cyc [$];

  int n_checks;
  int n_fail;
  int rr_seq [3];

  function automatic logic [63:0] enc(input logic u, input logic l,
                                      input logic [3:0] d, input logic [31:0] x);
    return {26'd0, u, l, d, x};
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_heads();
    for (int c = 0; c < NCH; c++) begin
      if (fhead[c] < ftail[c]) begin
        fifo_not_empty_in[c]     = 1'b1;
        fifo_last_in[c]          = fmem[c][fhead[c]][32];
        fifo_data_in[c*FW +: FW] = fmem[c][fhead[c]][31:0];
      end else begin
        fifo_not_empty_in[c]     = 1'b0;
        fifo_last_in[c]          = 1'b0;
        fifo_data_in[c*FW +: FW] = '0;
      end
    end
  endtask

  task automatic push(input int c, input logic [31:0] d, input logic l);
    fmem[c][ftail[c]] = {l, d};
    ftail[c]++;
    drive_heads();
  endtask

  task automatic expect_beat(input int cy, input logic u, input logic l,
                             input logic [3:0] d, input logic [31:0] x);
    exp_q.push_back(enc(u, l, d, x));
    exp_cyc.push_back(cy);
  endtask

  task automatic clear_logs();
    exp_q.delete();
    exp_cyc.delete();
    got_q.delete();
    got_cyc.delete();
  endtask

  // One clock cycle: sample, log, then advance past the edge and pop.
  task automatic tick();
    logic [3:0] stb_pre;
    logic [63:0] ow;
    #1;
    ow = enc(SINK_AXIS_tuser_out, SINK_AXIS_tlast_out, SINK_AXIS_tdest_out,
             SINK_AXIS_tdata_out);
    stb_pre = fifo_r_stb_out;
    if (cyc < LOGN) begin
      out_log[cyc]   = ow;
      vld_log[cyc]   = SINK_AXIS_tvalid_out;
      stb_log[cyc]   = stb_pre;
      trunc_log[cyc] = pkt_trunc_out;
      dbg_log[cyc]   = dbg_state_out;
      chan_log[cyc]  = cur_chan_out;
    end
    check("stb_onehot0", 64'($onehot0(stb_pre)), 64'd1);
    if (SINK_AXIS_tvalid_out && SINK_AXIS_tready_in) begin
      got_q.push_back(ow);
      got_cyc.push_back(cyc);
    end
    @(posedge clk_in);
    #1;
    cyc++;
    for (int c = 0; c < NCH; c++) begin
      if (stb_pre[c] && fhead[c] < ftail[c]) fhead[c]++;
    end
    drive_heads();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic compare_beats(input string tag);
    int n;
    check({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_beat%0d", tag, i), got_q[i], exp_q[i]);
      check($sformatf("%s_cyc%0d", tag, i), 64'(got_cyc[i]), 64'(exp_cyc[i]));
    end
  endtask

  task automatic do_reset();
    rst_n_in = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      fhead[c] = 0;
      ftail[c] = 0;
    end
    drive_heads();
    SINK_AXIS_tready_in = 1'b1;
    channel_mask_in     = '1;
    ticks(2);
    rst_n_in = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int c1;
    int cnt;
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    rr_seq[0] = 0;
    rr_seq[1] = 1;
    rr_seq[2] = 3;
    for (int c = 0; c < NCH; c++) begin
      fhead[c] = 0;
      ftail[c] = 0;
    end
    SINK_AXIS_tready_in = 1'b1;
    channel_mask_in     = '1;
    fifo_data_in        = '0;
    fifo_not_empty_in   = '0;
    fifo_last_in        = '0;
    drive_heads();

    // ---- reset state ----
    rst_n_in = 1'b0;
    ticks(2);
    check("rst_tvalid", 64'(SINK_AXIS_tvalid_out), 64'd0);
    check("rst_tdata",  64'(SINK_AXIS_tdata_out),  64'd0);
    check("rst_tdest",  64'(SINK_AXIS_tdest_out),  64'd0);
    check("rst_tlast",  64'(SINK_AXIS_tlast_out),  64'd0);
    check("rst_tuser",  64'(SINK_AXIS_tuser_out),  64'd0);
    check("rst_tkeep",  64'(SINK_AXIS_tkeep_out),  64'hF);
    check("rst_stb",    64'(fifo_r_stb_out),       64'd0);
    check("rst_chan",   64'(cur_chan_out),         64'd0);
    check("rst_trunc",  64'(pkt_trunc_out),        64'd0);
    check("rst_dbg",    64'(dbg_state_out),        64'd0);
    rst_n_in = 1'b1;
    ticks(2);
    check("idle_dbg", 64'(dbg_state_out), 64'd0);

    // ---- single channel: ch2, A0..A3 ----
    clear_logs();
    c0 = cyc;
    for (int j = 0; j < 4; j++) push(2, 32'hA0 + 32'(j), j == 3);
    ticks(8);
    for (int j = 0; j < 4; j++) expect_beat(c0 + 2 + j, 1'b0, j == 3, 4'd2, 32'hA0 + 32'(j));
    compare_beats("single");
    check("single_stb_c0",   64'(stb_log[c0]),     64'd0);
    check("single_vld_lat",  64'(vld_log[c0 + 1]), 64'd0);
    check("single_vld_on",   64'(vld_log[c0 + 2]), 64'd1);
    for (int j = 1; j <= 4; j++) check($sformatf("single_stb%0d", j), 64'(stb_log[c0 + j]), 64'h4);
    check("single_stb_end",  64'(stb_log[c0 + 5]), 64'd0);

    // ---- round robin / atomicity: ch0,1,3 two 3-beat packets each ----
    do_reset();
    clear_logs();
    c0 = cyc;
    for (int p = 0; p < 2; p++)
      for (int s = 0; s < 3; s++)
        for (int j = 0; j < 3; j++)
          push(rr_seq[s], 32'((rr_seq[s] << 8) | (p * 3 + j)), j == 2);
    ticks(30);
    for (int k = 0; k < 6; k++)
      for (int j = 0; j < 3; j++)
        expect_beat(c0 + 2 + 4 * k + j, 1'b0, j == 2, 4'(rr_seq[k % 3]),
                    32'((rr_seq[k % 3] << 8) | ((k / 3) * 3 + j)));
    compare_beats("rr");

    // ---- back-pressure: ch1 B0..B3, tready low 3 cycles on beat 2 ----
    clear_logs();
    c0 = cyc;
    for (int j = 0; j < 4; j++) push(1, 32'hB0 + 32'(j), j == 3);
    for (int k = 0; k < 12; k++) begin
      SINK_AXIS_tready_in = !(k >= 3 && k <= 5);
      tick();
    end
    SINK_AXIS_tready_in = 1'b1;
    expect_beat(c0 + 2, 1'b0, 1'b0, 4'd1, 32'hB0);
    expect_beat(c0 + 6, 1'b0, 1'b0, 4'd1, 32'hB1);
    expect_beat(c0 + 7, 1'b0, 1'b0, 4'd1, 32'hB2);
    expect_beat(c0 + 8, 1'b0, 1'b1, 4'd1, 32'hB3);
    compare_beats("bp");
    for (int k = 3; k <= 5; k++) begin
      check($sformatf("bp_hold%0d", k), out_log[c0 + k], enc(1'b0, 1'b0, 4'd1, 32'hB1));
      check($sformatf("bp_vld%0d", k),  64'(vld_log[c0 + k]), 64'd1);
      check($sformatf("bp_stb%0d", k),  64'(stb_log[c0 + k]), 64'd0);
    end

    // ---- truncation: ch1 6-word packet, limit 4 ----
    clear_logs();
    c0 = cyc;
    for (int j = 0; j < 6; j++) push(1, 32'hC0 + 32'(j), j == 5);
    ticks(12);
    for (int j = 0; j < 3; j++) expect_beat(c0 + 2 + j, 1'b0, 1'b0, 4'd1, 32'hC0 + 32'(j));
    expect_beat(c0 + 5, 1'b1, 1'b1, 4'd1, 32'hC3);
    expect_beat(c0 + 7, 1'b0, 1'b0, 4'd1, 32'hC4);
    expect_beat(c0 + 8, 1'b0, 1'b1, 4'd1, 32'hC5);
    compare_beats("trunc");
    check("trunc_pulse", 64'(trunc_log[c0 + 5]), 64'd1);
    cnt = 0;
    for (int k = 0; k < 12; k++) cnt += int'(trunc_log[c0 + k]);
    check("trunc_pulse_count", 64'(cnt), 64'd1);

    // ---- mask and empty mid-packet on ch0 ----
    clear_logs();
    c0 = cyc;
    push(0, 32'hD0, 1'b0);
    push(0, 32'hD1, 1'b0);
    tick();
    channel_mask_in = 4'b1110;
    push(2, 32'hE0, 1'b1);
    ticks(7);
    push(0, 32'hD2, 1'b0);
    push(0, 32'hD3, 1'b1);
    push(0, 32'hD4, 1'b1);
    ticks(14);
    expect_beat(c0 + 2,  1'b0, 1'b0, 4'd0, 32'hD0);
    expect_beat(c0 + 3,  1'b0, 1'b0, 4'd0, 32'hD1);
    expect_beat(c0 + 9,  1'b0, 1'b0, 4'd0, 32'hD2);
    expect_beat(c0 + 10, 1'b0, 1'b1, 4'd0, 32'hD3);
    expect_beat(c0 + 12, 1'b0, 1'b1, 4'd2, 32'hE0);
    compare_beats("mask");
    for (int k = 3; k <= 7; k++) begin
      check($sformatf("empty_stb%0d", k),  64'(stb_log[c0 + k]),  64'd0);
      check($sformatf("empty_dbg%0d", k),  64'(dbg_log[c0 + k]),  64'd1);
      check($sformatf("empty_chan%0d", k), 64'(chan_log[c0 + k]), 64'd0);
    end
    cnt = 0;
    for (int k = 11; k <= 21; k++) cnt += int'(stb_log[c0 + k][0]);
    check("mask_no_ch0_pop", 64'(cnt), 64'd0);
    check("mask_idle_end", 64'(dbg_log[c0 + 21]), 64'd0);

    // ---- reset mid-packet on ch3 ----
    do_reset();
    clear_logs();
    c0 = cyc;
    for (int j = 0; j < 4; j++) push(3, 32'hF0 + 32'(j), j == 3);
    ticks(3);
    push(1, 32'h60, 1'b1);
    check("pre_rst_vld", 64'(SINK_AXIS_tvalid_out), 64'd1);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_tvalid", 64'(SINK_AXIS_tvalid_out), 64'd0);
    check("midrst_stb",    64'(fifo_r_stb_out),       64'd0);
    check("midrst_dbg",    64'(dbg_state_out),        64'd0);
    check("midrst_tdata",  64'(SINK_AXIS_tdata_out),  64'd0);
    tick();
    clear_logs();
    rst_n_in = 1'b1;
    c1 = cyc;
    ticks(10);
    expect_beat(c1 + 2, 1'b0, 1'b1, 4'd1, 32'h60);
    expect_beat(c1 + 4, 1'b0, 1'b0, 4'd3, 32'hF2);
    expect_beat(c1 + 5, 1'b0, 1'b1, 4'd3, 32'hF3);
    compare_beats("postrst");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
